// File: rtl/div_result_bcd.sv
// Converts an 8-bit quotient/remainder pair to 3-digit BCD with an iterative double-dabble.
// Optional leading-zero blanking (4'hF nibbles) with BCD_BLANK_LEADING_ZERO_EN.

module div_result_bcd_dd_step #(
  parameter int OP_W  = 8,
  parameter int BCD_W = 12
) (
  input  logic [BCD_W-1:0] acc,
  input  logic [OP_W-1:0]  sh,
  output logic [BCD_W-1:0] acc_nx,
  output logic [OP_W-1:0]  sh_nx
);
  localparam int DIGITS = BCD_W / 4;

  logic [BCD_W-1:0] adj;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
  end

  assign {acc_nx, sh_nx} = {adj[BCD_W-2:0], sh, 1'b0};
endmodule

module div_result_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  quotient_in,
  input  logic [7:0]  remainder_in,
  output logic        busy,
  output logic        out_valid,
  output logic [11:0] q_bcd,
  output logic [11:0] r_bcd,
  output logic        overrun
);
  localparam int NUM_OPS = 2;
  localparam int OP_W    = 8;
  localparam int BCD_W   = 12;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t state, state_nx;
  logic [2:0] cnt;
  logic [NUM_OPS-1:0][OP_W-1:0]  sh, sh_nx, ops;
  logic [NUM_OPS-1:0][BCD_W-1:0] acc, acc_nx;

  // Lane 0 carries the quotient, lane 1 the remainder.
  assign ops = {remainder_in, quotient_in};

  for (genvar l = 0; l < NUM_OPS; l++) begin : g_lane
    div_result_bcd_dd_step #(.OP_W(OP_W), .BCD_W(BCD_W)) u_step (
      .acc    (acc[l]),
      .sh     (sh[l]),
      .acc_nx (acc_nx[l]),
      .sh_nx  (sh_nx[l])
    );
  end

  function automatic logic [BCD_W-1:0] fmt(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] o;
    o = b;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (b[11:8] == 4'd0) o[11:8] = 4'hF;
    if (b[11:4] == 8'd0) o[7:4]  = 4'hF;
`endif
    return o;
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == 3'd7) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      q_bcd     <= '0;
      r_bcd     <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          sh  <= ops;
          acc <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          sh      <= sh_nx;
          acc     <= acc_nx;
          cnt     <= cnt + 3'd1;
          overrun <= in_valid;
          // Publish straight from the last step so outputs never show partial sums.
          if (cnt == 3'd7) begin
            out_valid <= 1'b1;
            q_bcd     <= fmt(acc_nx[0]);
            r_bcd     <= fmt(acc_nx[1]);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign busy = (state == SHIFT);
endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: directed cases plus randomized pairs vs. an arithmetic BCD model.
module tb_div_result_bcd;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  quotient_in = '0;
  logic [7:0]  remainder_in = '0;
  logic        busy, out_valid, overrun;
  logic [11:0] q_bcd, r_bcd;

  int checks = 0;
  int errors = 0;
  logic [11:0] last_q = '0;
  logic [11:0] last_r = '0;

  div_result_bcd dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .quotient_in(quotient_in), .remainder_in(remainder_in),
    .busy(busy), .out_valid(out_valid), .q_bcd(q_bcd), .r_bcd(r_bcd),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (v < 100) h = 4'hF;
    if (v < 10)  t = 4'hF;
`endif
    return {h, t, u};
  endfunction

  // Called at #1 after an edge; in_valid is captured on the next edge.
  task automatic start(input logic [7:0] q, input logic [7:0] r);
    in_valid = 1'b1; quotient_in = q; remainder_in = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL start_busy: busy=%b required 1", busy);
    end
  endtask

  // Walks the 8 shift edges; result must appear on exactly the 8th.
  task automatic wait_result(input logic [7:0] q, input logic [7:0] r, input string name);
    logic [11:0] eq, er;
    eq = ref_bcd(int'(q)); er = ref_bcd(int'(r));
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (i < 8) begin
        if (out_valid !== 1'b0 || busy !== 1'b1 || q_bcd !== last_q || r_bcd !== last_r) begin
          errors++;
          $display("FAIL %s step%0d: out_valid=%b busy=%b q=%h r=%h required 0 1 %h %h",
                   name, i, out_valid, busy, q_bcd, r_bcd, last_q, last_r);
        end
      end else begin
        if (out_valid !== 1'b1 || busy !== 1'b0 || q_bcd !== eq || r_bcd !== er) begin
          errors++;
          $display("FAIL %s result: out_valid=%b busy=%b q=%h r=%h required 1 0 %h %h",
                   name, out_valid, busy, q_bcd, r_bcd, eq, er);
        end
      end
    end
    last_q = eq; last_r = er;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (busy !== 0 || out_valid !== 0 || overrun !== 0 || q_bcd !== 12'h000 || r_bcd !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: busy=%b ov=%b orun=%b q=%h r=%h required all zero",
               busy, out_valid, overrun, q_bcd, r_bcd);
    end
    // First edge after release must accept a request.
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; quotient_in = 8'd28; remainder_in = 8'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL first_edge_accept: busy=%b required 1", busy);
    end
    wait_result(8'd28, 8'd4, "conv_28_4");
  endtask

  task automatic test_max();
    @(posedge clk); #1;
    start(8'd255, 8'd0);
    wait_result(8'd255, 8'd0, "conv_255_0");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 0 || out_valid !== 0 || q_bcd !== last_q || r_bcd !== last_r) begin
      errors++;
      $display("FAIL hold_idle: busy=%b ov=%b q=%h r=%h required 0 0 %h %h",
               busy, out_valid, q_bcd, r_bcd, last_q, last_r);
    end
  endtask

  task automatic test_overrun();
    start(8'd50, 8'd7);                 // capture edge E0
    @(posedge clk); #1;                 // E1
    @(posedge clk); #1;                 // E2
    in_valid = 1'b1; quotient_in = 8'd9; remainder_in = 8'd1;
    @(posedge clk); #1;                 // E3 drops the request
    in_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_pulse: overrun=%b required 1", overrun);
    end
    @(posedge clk); #1;                 // E4
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_one_cycle: overrun=%b required 0", overrun);
    end
    repeat (3) @(posedge clk);          // E5..E7
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL overrun_e7: out_valid=%b busy=%b required 0 1", out_valid, busy);
    end
    @(posedge clk); #1;                 // E8
    checks++;
    if (out_valid !== 1'b1 || q_bcd !== ref_bcd(50) || r_bcd !== ref_bcd(7)) begin
      errors++;
      $display("FAIL overrun_result: out_valid=%b q=%h r=%h required 1 %h %h",
               out_valid, q_bcd, r_bcd, ref_bcd(50), ref_bcd(7));
    end
    last_q = ref_bcd(50); last_r = ref_bcd(7);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || overrun !== 1'b0 || q_bcd !== last_q) begin
        errors++;
        $display("FAIL overrun_no_second: cyc%0d out_valid=%b overrun=%b q=%h required 0 0 %h",
                 i, out_valid, overrun, q_bcd, last_q);
      end
    end
  endtask

  task automatic test_back_to_back();
    start(8'd31, 8'd5);
    wait_result(8'd31, 8'd5, "b2b_first");
    // Now in the out_valid cycle; request must be taken with no gap.
    start(8'd100, 8'd99);
    wait_result(8'd100, 8'd99, "b2b_second");
  endtask

  task automatic test_random();
    logic [7:0] q, r;
    for (int n = 0; n < 24; n++) begin
      q = 8'($urandom_range(0, 255));
      r = 8'($urandom_range(0, 255));
      start(q, r);
      wait_result(q, r, "random");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      if (!out_valid) begin end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start(8'd200, 8'd150);
    repeat (4) @(posedge clk);          // count now 4
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 0 || out_valid !== 0 || overrun !== 0 || q_bcd !== 12'h000 || r_bcd !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: busy=%b ov=%b orun=%b q=%h r=%h required all zero",
               busy, out_valid, overrun, q_bcd, r_bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_q = 12'h000; last_r = 12'h000;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort cyc%0d: out_valid=%b busy=%b required 0 0", i, out_valid, busy);
      end
    end
    start(8'd0, 8'd0);
    wait_result(8'd0, 8'd0, "conv_0_0");
  endtask

  initial begin
    test_reset();
    test_max();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
